// File: rtl/key_entry.sv
// Keypad front-end: synchronises and debounces the raw keypad, collects digits
// into a CODE_LEN-nibble word and submits it to the code-lock comparator on ENTER.
module key_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CODE_LEN        = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter logic [3:0]  ENTER_KEY       = 4'hE,
    parameter logic [3:0]  CLEAR_KEY       = 4'hF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_down,
    input  logic [3:0]                        key_code,
    input  logic                              lockout,
    output logic [3:0]                        digit,
    output logic                              digit_valid,
    output logic [4*CODE_LEN-1:0]             code,
    output logic                              code_valid,
    output logic [$clog2(CODE_LEN+1)-1:0]     entry_count,
    output logic                              entry_error,
    output logic                              timeout
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int CNT_W = $clog2(CODE_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int BUF_W = 4 * CODE_LEN;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CODE_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_e;

    // Two-flop synchronisers; nothing downstream looks at the raw inputs.
    logic       kd_meta, kd_sync;
    logic [3:0] kc_meta, kc_sync;
    logic       lk_meta, lk_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kd_meta <= 1'b0;
            kd_sync <= 1'b0;
            kc_meta <= 4'h0;
            kc_sync <= 4'h0;
            lk_meta <= 1'b0;
            lk_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value.
            kd_meta <= key_down;
            kd_sync <= kd_meta;
            kc_meta <= key_code;
            kc_sync <= kc_meta;
            lk_meta <= lockout;
            lk_sync <= lk_meta;
        end
    end

    state_e          state, state_n;
    logic [DB_W-1:0] db_cnt, db_cnt_n;
    logic [3:0]      cap_code, cap_code_n;
    logic            accept_q, accept_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            db_cnt   <= '0;
            cap_code <= 4'h0;
            accept_q <= 1'b0;
        end else begin
            state    <= state_n;
            db_cnt   <= db_cnt_n;
            cap_code <= cap_code_n;
            accept_q <= accept_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n    = state;
        db_cnt_n   = db_cnt;
        cap_code_n = cap_code;
        accept_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (kd_sync) begin
                    state_n    = DB_PRESS;
                    cap_code_n = kc_sync;
                    db_cnt_n   = '0;
                end
            end
            DB_PRESS: begin
                if (!kd_sync || (kc_sync != cap_code)) begin
                    state_n = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_n  = PRESSED;
                    accept_n = 1'b1;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!kd_sync) begin
                    state_n  = DB_RELEASE;
                    db_cnt_n = '0;
                end
            end
            DB_RELEASE: begin
                // A bounce back high resumes the same press instead of starting a new one.
                if (kd_sync) begin
                    state_n = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_n = IDLE;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Entry datapath: acts on the registered accept strobe, one cycle after debounce completes.
    logic [BUF_W-1:0] buffer;
    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer      <= '0;
            timer       <= '0;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            code        <= '0;
            code_valid  <= 1'b0;
            entry_count <= '0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            code_valid  <= 1'b0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;
            if (lk_sync) begin
                buffer      <= '0;
                entry_count <= '0;
                timer       <= '0;
            end else if (accept_q) begin
                timer <= '0;
                if (cap_code == ENTER_KEY) begin
                    if (entry_count == CNT_FULL) begin
                        code       <= buffer;
                        code_valid <= 1'b1;
                    end else begin
                        entry_error <= 1'b1;
                    end
                    buffer      <= '0;
                    entry_count <= '0;
                end else if (cap_code == CLEAR_KEY) begin
                    buffer      <= '0;
                    entry_count <= '0;
                end else if (entry_count == CNT_FULL) begin
                    entry_error <= 1'b1;
                end else begin
                    buffer      <= (buffer << 4) | BUF_W'(cap_code);
                    entry_count <= entry_count + 1'b1;
                    digit       <= cap_code;
                    digit_valid <= 1'b1;
                end
            end else if (entry_count == '0) begin
                timer <= '0;
            end else if (state == IDLE) begin
                if (timer == TMR_LAST) begin
                    buffer      <= '0;
                    entry_count <= '0;
                    timer       <= '0;
                    timeout     <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// Directed bench for key_entry: expected pulses are queued as keys are driven
// and checked by a negedge monitor; latency and hold values checked inline.
module tb_key_entry;

    typedef enum logic [1:0] {EV_DIGIT, EV_CODE, EV_ERR, EV_TO} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [15:0] val;
        logic [2:0]  cnt;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_down = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        lockout = 1'b0;
    logic [3:0]  digit;
    logic        digit_valid;
    logic [15:0] code;
    logic        code_valid;
    logic [2:0]  entry_count;
    logic        entry_error;
    logic        timeout;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  last_lat;
    ev_t sb[$];
    ev_t mon_ev;

    key_entry #(
        .DEBOUNCE_CYCLES(4),
        .CODE_LEN       (4),
        .TIMEOUT_CYCLES (64),
        .ENTER_KEY      (4'hE),
        .CLEAR_KEY      (4'hF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_down   (key_down),
        .key_code   (key_code),
        .lockout    (lockout),
        .digit      (digit),
        .digit_valid(digit_valid),
        .code       (code),
        .code_valid (code_valid),
        .entry_count(entry_count),
        .entry_error(entry_error),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input ev_kind_e kind, input logic [15:0] val, input logic [2:0] cnt);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    // Press held for 'hold' cycles; records cycles from the first sampling edge to the first pulse.
    task automatic press(input logic [3:0] key, input int hold, input int gap);
        @(negedge clk);
        key_down = 1'b1;
        key_code = key;
        last_lat = -1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if ((digit_valid | code_valid | entry_error | timeout) && last_lat < 0) last_lat = k;
        end
        @(negedge clk);
        key_down = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && (digit_valid | code_valid | entry_error | timeout)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {28'h0, timeout, entry_error, code_valid, digit_valid}, 32'h0);
            end else begin
                mon_ev = sb.pop_front();
                check("pulse_kind", {28'h0, timeout, entry_error, code_valid, digit_valid},
                      32'(4'b0001 << mon_ev.kind));
                if (mon_ev.kind == EV_DIGIT) check("digit", 32'(digit), 32'(mon_ev.val[3:0]));
                else                         check("code", 32'(code), 32'(mon_ev.val));
                check("entry_count_at_pulse", 32'(entry_count), 32'(mon_ev.cnt));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pulses", {28'h0, timeout, entry_error, code_valid, digit_valid}, 32'h0);
        check("rst_code", 32'(code), 32'h0);
        check("rst_count", 32'(entry_count), 32'h0);
        check("rst_digit", 32'(digit), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Clean entry 1,2,3,4,ENTER
        push(EV_DIGIT, 16'h1, 3'd1);
        press(4'h1, 10, 10);
        check("latency_first", 32'(last_lat), 32'd7);
        push(EV_DIGIT, 16'h2, 3'd2); press(4'h2, 10, 10);
        push(EV_DIGIT, 16'h3, 3'd3); press(4'h3, 10, 10);
        push(EV_DIGIT, 16'h4, 3'd4); press(4'h4, 10, 10);
        check("latency_fourth", 32'(last_lat), 32'd7);
        push(EV_CODE, 16'h1234, 3'd0); press(4'hE, 10, 10);
        check("code_hold", 32'(code), 32'h1234);

        // Press bounce then a held 5, with a release bounce
        key_code = 4'h5;
        repeat (2) begin
            @(negedge clk); key_down = 1'b1;
            @(negedge clk);
            @(negedge clk); key_down = 1'b0;
            @(negedge clk);
        end
        push(EV_DIGIT, 16'h5, 3'd1);
        press(4'h5, 10, 0);
        @(negedge clk); key_down = 1'b1;
        @(negedge clk); key_down = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_count", 32'(entry_count), 32'd1);
        press(4'hF, 10, 10);
        check("clear_count", 32'(entry_count), 32'd0);

        // Short entry then overflow digit
        push(EV_DIGIT, 16'h1, 3'd1); press(4'h1, 10, 10);
        push(EV_DIGIT, 16'h2, 3'd2); press(4'h2, 10, 10);
        push(EV_ERR, 16'h1234, 3'd0); press(4'hE, 10, 10);
        check("short_enter_count", 32'(entry_count), 32'd0);
        push(EV_DIGIT, 16'h1, 3'd1); press(4'h1, 10, 10);
        push(EV_DIGIT, 16'h2, 3'd2); press(4'h2, 10, 10);
        push(EV_DIGIT, 16'h3, 3'd3); press(4'h3, 10, 10);
        push(EV_DIGIT, 16'h4, 3'd4); press(4'h4, 10, 10);
        push(EV_ERR, 16'h1234, 3'd4); press(4'h7, 10, 10);
        check("overflow_digit_hold", 32'(digit), 32'h4);
        push(EV_CODE, 16'h1234, 3'd0); press(4'hE, 10, 10);

        // Inactivity timeout, then activity inside the window
        push(EV_DIGIT, 16'h9, 3'd1); press(4'h9, 10, 10);
        push(EV_TO, 16'h1234, 3'd0);
        repeat (80) @(negedge clk);
        check("timeout_count", 32'(entry_count), 32'd0);
        push(EV_DIGIT, 16'h9, 3'd1); press(4'h9, 10, 10);
        repeat (40) @(negedge clk);
        push(EV_DIGIT, 16'h8, 3'd2); press(4'h8, 10, 10);
        check("no_timeout_count", 32'(entry_count), 32'd2);

        // Lockout clears the buffer and discards keys, including one held across its end
        lockout = 1'b1;
        repeat (4) @(negedge clk);
        check("lockout_clear", 32'(entry_count), 32'd0);
        press(4'h3, 10, 10);
        check("lockout_press", 32'(entry_count), 32'd0);
        @(negedge clk);
        key_down = 1'b1; key_code = 4'h6;
        repeat (12) @(negedge clk);
        lockout = 1'b0;
        repeat (10) @(negedge clk);
        key_down = 1'b0;
        repeat (12) @(negedge clk);
        check("held_across_lockout", 32'(entry_count), 32'd0);

        // Reset in the middle of a debounce with 3 digits buffered
        push(EV_DIGIT, 16'h4, 3'd1); press(4'h4, 10, 10);
        push(EV_DIGIT, 16'h1, 3'd2); press(4'h1, 10, 10);
        push(EV_DIGIT, 16'h2, 3'd3); press(4'h2, 10, 10);
        check("pre_reset_count", 32'(entry_count), 32'd3);
        check("sb_empty_pre_reset", 32'(sb.size()), 32'd0);
        @(negedge clk);
        key_down = 1'b1; key_code = 4'h5;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_pulses", {28'h0, timeout, entry_error, code_valid, digit_valid}, 32'h0);
        check("mid_rst_code", 32'(code), 32'h0);
        check("mid_rst_count", 32'(entry_count), 32'd0);
        check("mid_rst_digit", 32'(digit), 32'h0);
        push(EV_DIGIT, 16'h5, 3'd1);
        rst = 1'b1;
        last_lat = -1;
        for (int k = 0; k < 30 && last_lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (digit_valid) last_lat = k;
        end
        check("post_reset_latency", 32'(last_lat), 32'd7);
        @(negedge clk);
        key_down = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_count", 32'(entry_count), 32'd1);
        check("post_reset_code", 32'(code), 32'h0);
        check("sb_empty_final", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
